// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator command path.
package calc_pkg;

  localparam int unsigned OPW   = 2;
  localparam int unsigned DW    = 4;
  localparam int unsigned RAW   = DW + 1;
  localparam int unsigned CMD_W = OPW + 2 * DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO; full/empty decoded from the registered occupancy.
module calc_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents only matter once written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Queues host commands, issues them to the calculator one at a time,
// waits a fixed latency and returns the captured results.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_op,
  input  logic [DW-1:0]  cmd_a,
  input  logic [DW-1:0]  cmd_b,
  output logic           Start,
  output logic [OPW-1:0] SIR,
  output logic [DW-1:0]  SA,
  output logic [DW-1:0]  SB,
  input  logic [DW:0]    resultA,
  input  logic [DW-1:0]  resultB,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [OPW-1:0] rsp_op,
  output logic [DW:0]    rsp_a,
  output logic [DW-1:0]  rsp_b,
  output logic           busy
);

  localparam int unsigned CNTW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t           state;
  state_t           state_d;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_d;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  cmd_t             cmd_in;
  cmd_t             head;
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;

  logic             start_d;
  logic [OPW-1:0]   sir_d;
  logic [DW-1:0]    sa_d;
  logic [DW-1:0]    sb_d;
  logic             rsp_valid_d;
  logic [OPW-1:0]   rsp_op_d;
  logic [DW:0]      rsp_a_d;
  logic [DW-1:0]    rsp_b_d;
  logic             busy_d;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign fifo_din  = cmd_in;
  assign head      = cmd_t'(fifo_dout);

  calc_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, pop decision and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pop         = 1'b0;
    start_d     = 1'b0;
    sir_d       = SIR;
    sa_d        = SA;
    sb_d        = SB;
    rsp_valid_d = rsp_valid;
    rsp_op_d    = rsp_op;
    rsp_a_d     = rsp_a;
    rsp_b_d     = rsp_b;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sir_d   = head.op;
          sa_d    = head.a;
          sb_d    = head.b;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNTW'(WAIT_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          rsp_valid_d = 1'b1;
          rsp_op_d    = SIR;
          rsp_a_d     = resultA;
          rsp_b_d     = resultB;
          state_d     = RESP;
        end else begin
          cnt_d = cnt - CNTW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop only happens on the way out of IDLE, so the queue is non-empty
    // after this edge exactly when it already was or a push lands now.
    busy_d = (state_d != IDLE) || !empty || push;
  end

  // Registered calculator drive, response and busy outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      Start     <= 1'b0;
      SIR       <= '0;
      SA        <= '0;
      SB        <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= '0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      busy      <= 1'b0;
    end else begin
      Start     <= start_d;
      SIR       <= sir_d;
      SA        <= sa_d;
      SB        <= sb_d;
      rsp_valid <= rsp_valid_d;
      rsp_op    <= rsp_op_d;
      rsp_a     <= rsp_a_d;
      rsp_b     <= rsp_b_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// Directed bench for calc_cmd_driver with a latency-accurate calculator stub.
module tb_calc_cmd_driver;
  import calc_pkg::*;

  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned WAIT_CYCLES = 4;

  logic           clk;
  logic           rst_;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_op;
  logic [DW-1:0]  cmd_a;
  logic [DW-1:0]  cmd_b;
  logic           Start;
  logic [OPW-1:0] SIR;
  logic [DW-1:0]  SA;
  logic [DW-1:0]  SB;
  logic [DW:0]    resultA;
  logic [DW-1:0]  resultB;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [OPW-1:0] rsp_op;
  logic [DW:0]    rsp_a;
  logic [DW-1:0]  rsp_b;
  logic           busy;

  int total;
  int bad;
  int start_cnt;
  logic [2:0] scnt;

  calc_cmd_driver #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .Start     (Start),
    .SIR       (SIR),
    .SA        (SA),
    .SB        (SB),
    .resultA   (resultA),
    .resultB   (resultB),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op    (rsp_op),
    .rsp_a     (rsp_a),
    .rsp_b     (rsp_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator stub: results are correct only WAIT_CYCLES cycles after Start.
  always @(posedge clk or negedge rst_) begin
    if (!rst_) scnt <= 3'd0;
    else if (Start === 1'b1) scnt <= 3'd1;
    else if (scnt != 3'd0 && scnt < 3'd7) scnt <= scnt + 3'd1;
  end
  assign resultA = (scnt == 3'(WAIT_CYCLES)) ? ({1'b0, SA} + {1'b0, SB}) : 5'h15;
  assign resultB = (scnt == 3'(WAIT_CYCLES)) ? (SA ^ SB) : 4'hA;

  // Counts cycles in which Start is high.
  always @(posedge clk) begin
    if (Start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_timeout cmd_ready=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL rsp_wait_timeout rsp_valid=%b want=1", rsp_valid);
    end
  endtask

  task automatic take_rsp(output logic [1:0] op, output logic [4:0] a, output logic [3:0] b);
    wait_valid();
    op = rsp_op; a = rsp_a; b = rsp_b;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (Start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", Start); end
    total++; if ({SIR, SA, SB} !== 10'd0) begin bad++; $display("FAIL reset_sir_sa_sb got=%h want=0", {SIR, SA, SB}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({rsp_op, rsp_a, rsp_b} !== 11'd0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", {rsp_op, rsp_a, rsp_b}); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || Start !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b start=%b want=0,0", busy, Start); end
  endtask

  task automatic test_single();
    int ks, kr, starts;
    ks = -1; kr = -1; starts = 0;
    push(2'd0, 4'd4, 4'd5);
    for (int i = 0; i < 30; i++) begin
      if (Start === 1'b1) begin
        starts++;
        ks = i;
        total++;
        if ({SIR, SA, SB} !== {2'd0, 4'd4, 4'd5}) begin
          bad++; $display("FAIL single_drive got=%h want=%h", {SIR, SA, SB}, {2'd0, 4'd4, 4'd5});
        end
      end
      if (rsp_valid === 1'b1) begin
        kr = i;
        break;
      end
      @(negedge clk);
    end
    total++; if (starts != 1) begin bad++; $display("FAIL single_start_count got=%0d want=1", starts); end
    total++; if (kr - ks != 5) begin bad++; $display("FAIL single_latency got=%0d want=5", kr - ks); end
    total++; if ({rsp_op, rsp_a, rsp_b} !== {2'd0, 5'b01001, 4'b0001}) begin
      bad++; $display("FAIL single_rsp got=%0d/%0d/%0d want=0/9/1", rsp_op, rsp_a, rsp_b);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_release rsp_valid=%b busy=%b want=0,0", rsp_valid, busy);
    end
  endtask

  task automatic test_burst();
    logic [1:0] eop [5];
    logic [4:0] ea  [5];
    logic [3:0] eb  [5];
    logic [1:0] op;
    logic [4:0] a;
    logic [3:0] b;
    eop[0] = 2'd2; ea[0] = 5'd3;  eb[0] = 4'd3;
    eop[1] = 2'd1; ea[1] = 5'd9;  eb[1] = 4'd1;
    eop[2] = 2'd3; ea[2] = 5'd9;  eb[2] = 4'd1;
    eop[3] = 2'd2; ea[3] = 5'd16; eb[3] = 4'd8;
    eop[4] = 2'd0; ea[4] = 5'd30; eb[4] = 4'd0;
    push(2'd2, 4'd1, 4'd2);
    wait_valid();
    push(2'd1, 4'd4, 4'd5);
    push(2'd3, 4'd4, 4'd5);
    push(2'd2, 4'd4, 4'd12);
    push(2'd0, 4'd15, 4'd15);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL burst_full_ready got=%b want=0", cmd_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL burst_busy got=%b want=1", busy); end
    for (int i = 0; i < 5; i++) begin
      take_rsp(op, a, b);
      total++;
      if ({op, a, b} !== {eop[i], ea[i], eb[i]}) begin
        bad++; $display("FAIL burst_rsp%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, op, a, b, eop[i], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] op;
    logic [4:0] a;
    logic [3:0] b;
    int errs;
    push(2'd1, 4'd3, 4'd6);
    push(2'd2, 4'd7, 4'd7);
    wait_valid();
    total++; if ({rsp_op, rsp_a, rsp_b} !== {2'd1, 5'd9, 4'd5}) begin
      bad++; $display("FAIL bp_rsp got=%0d/%0d/%0d want=1/9/5", rsp_op, rsp_a, rsp_b);
    end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || Start !== 1'b0 || {rsp_op, rsp_a, rsp_b} !== {2'd1, 5'd9, 4'd5}) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold unstable_cycles=%0d want=0", errs); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || Start !== 1'b0) begin
      bad++; $display("FAIL bp_after_hs rsp_valid=%b start=%b want=0,0", rsp_valid, Start);
    end
    @(negedge clk);
    total++; if (Start !== 1'b1 || {SIR, SA, SB} !== {2'd2, 4'd7, 4'd7}) begin
      bad++; $display("FAIL bp_next_start start=%b drive=%h want=1,%h", Start, {SIR, SA, SB}, {2'd2, 4'd7, 4'd7});
    end
    take_rsp(op, a, b);
    total++; if ({op, a, b} !== {2'd2, 5'd14, 4'd0}) begin
      bad++; $display("FAIL bp_rsp2 got=%0d/%0d/%0d want=2/14/0", op, a, b);
    end
  endtask

  task automatic test_full_pop();
    logic [1:0] eop [5];
    logic [4:0] ea  [5];
    logic [3:0] eb  [5];
    logic [1:0] op;
    logic [4:0] a;
    logic [3:0] b;
    int errs;
    eop[0] = 2'd0; ea[0] = 5'd2;  eb[0] = 4'd0;
    eop[1] = 2'd1; ea[1] = 5'd5;  eb[1] = 4'd1;
    eop[2] = 2'd2; ea[2] = 5'd16; eb[2] = 4'd0;
    eop[3] = 2'd3; ea[3] = 5'd16; eb[3] = 4'd14;
    eop[4] = 2'd0; ea[4] = 5'd15; eb[4] = 4'd15;
    push(2'd1, 4'd5, 4'd5);
    wait_valid();
    push(2'd0, 4'd1, 4'd1);
    push(2'd1, 4'd2, 4'd3);
    push(2'd2, 4'd8, 4'd8);
    push(2'd3, 4'd15, 4'd1);
    total++; if ({rsp_op, rsp_a, rsp_b} !== {2'd1, 5'd10, 4'd0}) begin
      bad++; $display("FAIL fp_primer got=%0d/%0d/%0d want=1/10/0", rsp_op, rsp_a, rsp_b);
    end
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'd9; cmd_b = 4'd6;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fp_pop_cycle_ready got=%b want=0", cmd_ready); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || Start !== 1'b1) begin
      bad++; $display("FAIL fp_after_pop ready=%b start=%b want=1,1", cmd_ready, Start);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      take_rsp(op, a, b);
      total++;
      if ({op, a, b} !== {eop[i], ea[i], eb[i]}) begin
        bad++; $display("FAIL fp_rsp%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, op, a, b, eop[i], ea[i], eb[i]);
      end
    end
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || Start !== 1'b0) errs++;
    end
    total++; if (errs != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL fp_drained extra_cycles=%0d busy=%b want=0,0", errs, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] op;
    logic [4:0] a;
    logic [3:0] b;
    int s0, errs;
    push(2'd1, 4'd6, 4'd6);
    push(2'd2, 4'd1, 4'd3);
    push(2'd3, 4'd2, 4'd5);
    total++; if (busy !== 1'b1 || Start !== 1'b0) begin
      bad++; $display("FAIL rm_in_wait busy=%b start=%b want=1,0", busy, Start);
    end
    rst_ = 1'b0;
    #1;
    total++; if ({Start, rsp_valid, busy, SIR, SA, SB} !== 13'd0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rm_async got=%h ready=%b want=0,1", {Start, rsp_valid, busy, SIR, SA, SB}, cmd_ready);
    end
    @(negedge clk);
    rst_ = 1'b1;
    s0 = start_cnt;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || Start !== 1'b0) errs++;
    end
    total++; if (errs != 0 || start_cnt != s0) begin
      bad++; $display("FAIL rm_quiet bad_cycles=%0d starts=%0d want=0,0", errs, start_cnt - s0);
    end
    push(2'd3, 4'd2, 4'd2);
    take_rsp(op, a, b);
    total++; if ({op, a, b} !== {2'd3, 5'd4, 4'd0}) begin
      bad++; $display("FAIL rm_new_cmd got=%0d/%0d/%0d want=3/4/0", op, a, b);
    end
  endtask

  initial begin
    total = 0; bad = 0; start_cnt = 0;
    rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
